// File: rtl/awgn_pkg.sv
// Shared constants and types for the AWGN frame controller: SNR-to-sigma
// table, SNR range limit and the frame sequencer state encoding.
package awgn_pkg;

  localparam logic [3:0] SNR_MAX = 4'd9;

  // Unsigned Q0.8 noise sigma for SNR index 0..9
  localparam logic [7:0] SIGMA_LUT [10] = '{
    8'd180, 8'd161, 8'd143, 8'd128, 8'd114,
    8'd102, 8'd90,  8'd81,  8'd72,  8'd64
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [7:0] snr_to_sigma(input logic [3:0] snr);
    return (snr > SNR_MAX) ? SIGMA_LUT[SNR_MAX] : SIGMA_LUT[snr];
  endfunction

endpackage

// File: rtl/awgn_frame_ctrl_if.sv
// Upstream complex-symbol valid/ready stream feeding the frame controller.
interface awgn_frame_ctrl_if #(
  parameter int W = 24
);

  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_real;
  logic signed [W-1:0] s_imag;

  modport master (output s_valid, s_real, s_imag, input s_ready);
  modport slave  (input s_valid, s_real, s_imag, output s_ready);

endinterface

// File: rtl/awgn_frame_ctrl.sv
// Frame sequencer for the AWGN channel: reseeds the noise generators, streams
// a frame of symbols into the datapath and tracks its latency to flag output.
module awgn_frame_ctrl
  import awgn_pkg::*;
#(
  parameter int W        = 24,
  parameter int LEN_W    = 19,
  parameter int LAT      = 2,
  parameter int SEED_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  awgn_frame_ctrl_if.slave    s,
  input  logic                start,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [3:0]          snr_db,
  output logic                ch_seed,
  output logic                ch_read,
  output logic signed [W-1:0] ch_x_real,
  output logic signed [W-1:0] ch_x_imag,
  output logic [7:0]          ch_sigma,
  output logic                m_valid,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    sym_count,
  output logic                err_snr
);

  localparam int SC_W = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [SC_W-1:0]  seed_cnt;
  logic [LAT-1:0]   vpipe;
  logic [LAT-1:0]   vpipe_shifted;
  logic             accept;
  logic             handshake;
  logic             last_sym;
  logic             seed_last;
  logic             pipe_empty;

  assign accept        = (state_q == ST_IDLE) && start;
  assign s.s_ready     = (state_q == ST_RUN) && (sym_count < len_q);
  assign handshake     = s.s_valid && s.s_ready;
  assign last_sym      = (sym_count + LEN_W'(1)) == len_q;
  assign seed_last     = seed_cnt == SC_W'(SEED_CYC - 1);
  assign vpipe_shifted = vpipe << 1;
  // Leaving DRAIN once only the final stage can still hold a sample lets
  // done land on the cycle right after the last m_valid.
  assign pipe_empty    = !ch_read && (vpipe_shifted == '0);
  assign m_valid       = vpipe[LAT-1];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ch_seed = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (frame_len == '0) ? ST_DONE : ST_SEED;
      end
      ST_SEED: begin
        ch_seed = 1'b1;
        busy    = 1'b1;
        if (seed_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (handshake && last_sym) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame command latch, symbol register, counters and the m_valid delay line
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_read   <= 1'b0;
      ch_x_real <= '0;
      ch_x_imag <= '0;
      ch_sigma  <= SIGMA_LUT[0];
      sym_count <= '0;
      len_q     <= '0;
      err_snr   <= 1'b0;
      seed_cnt  <= '0;
      vpipe     <= '0;
    end else begin
      ch_read  <= handshake;
      vpipe    <= vpipe_shifted | LAT'(ch_read);
      seed_cnt <= (state_q == ST_SEED) ? seed_cnt + SC_W'(1) : '0;
      if (handshake) begin
        ch_x_real <= s.s_real;
        ch_x_imag <= s.s_imag;
        sym_count <= sym_count + LEN_W'(1);
      end
      if (accept) begin
        len_q     <= frame_len;
        sym_count <= '0;
        ch_sigma  <= snr_to_sigma(snr_db);
        err_snr   <= snr_db > SNR_MAX;
      end
    end
  end

endmodule

// File: doc/awgn_frame_ctrl.md
# awgn_frame_ctrl

Frame sequencer for the AWGN channel datapath. It accepts a frame command (length, SNR index) and latches the SNR-to-sigma setting. It reseeds the noise generators, then streams complex symbols from an upstream valid/ready source into the datapath with one-cycle read strobes. It tracks the datapath latency, so it marks output samples valid and signals frame completion.

## Interface
Parameters:
- W, 24, symbol component width (matches datapath input width)
- LEN_W, 19, frame length counter width (max frame 2^LEN_W-1; 320000 fits)
- LAT, 2, datapath latency in cycles from ch_read to valid output
- SEED_CYC, 2, cycles ch_seed is held high before streaming

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  frame command pulse; sampled only in IDLE
- frame_len  in  LEN_W  symbols in frame; sampled with start
- snr_db  in  4  SNR index 0..9; sampled with start
- s_valid  in  1  upstream symbol valid
- s_ready  out  1  controller can accept symbol
- s_real, s_imag  in  W each  upstream symbol, signed
- ch_seed  out  1  active-high reseed/reset to noise generators
- ch_read  out  1  one-cycle strobe, symbol on ch_x_* valid
- ch_x_real, ch_x_imag  out  W each  registered symbol to datapath
- ch_sigma  out  8  unsigned Q0.8 sigma for latched SNR
- m_valid  out  1  datapath output sample valid this cycle (no backpressure)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end
- sym_count  out  LEN_W  symbols issued to datapath this frame
- err_snr  out  1  sticky: latched snr_db > 9, cleared on next accepted start

## Operation
- States: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE: s_ready=0. On start=1 with frame_len>0, latch len and SNR, clear sym_count, set busy, go SEED. On start=1 with frame_len=0, go DONE directly with no seed and sym_count=0.
- SEED: ch_seed=1 for exactly SEED_CYC cycles, then go RUN.
- RUN: s_ready=1 while sym_count<len. Each s_valid&&s_ready handshake registers s_real/s_imag into ch_x_*. It pulses ch_read on the next cycle and increments sym_count. Cycles where s_valid=0 produce no ch_read (gaps allowed). After the handshake that makes sym_count==len, s_ready drops the same edge; go DRAIN.
- DRAIN: wait until the LAT-deep valid pipeline is empty, then go DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- m_valid is a LAT-stage shift of ch_read and is independent of state.
- Sigma lookup for SNR 0..9: 180,161,143,128,114,102,90,81,72,64.
- snr_db > 9: clamp to 9 (sigma 64) and set err_snr.
- ch_sigma holds its value from the accepted start until the next accepted start.
- start while busy is ignored; the frame in progress is unaffected.
- sym_count holds its final value after done until the next accepted start.

## Timing
- Reset values: s_ready=0, ch_seed=0, ch_read=0, ch_x_*=0, ch_sigma=180, m_valid=0, busy=0, done=0, sym_count=0, err_snr=0; state IDLE.
- start at edge T: busy=1 and ch_seed=1 from T+1 through T+SEED_CYC; s_ready=1 from T+SEED_CYC+1.
- Handshake at edge H: ch_read=1 during cycle H+1; m_valid=1 during cycle H+1+LAT.
- Back-to-back handshakes give one symbol per cycle. Throughput is 1 symbol/clk.
- Last handshake at H: done pulses in cycle H+LAT+2; busy falls with it.
- Reset low mid-frame: every output returns to its reset value on that edge. In-flight m_valid stages are flushed and no done is issued.

## Structure
- Package awgn_pkg holds:
  - the SIGMA_LUT constant array (10 entries × 8 bits)
  - SNR_MAX=9
  - the state enum typedef
- No sub-module is required. The FSM, counter and valid shift register fit in one module, awgn_frame_ctrl.

## Test plan
- Reset/idle: hold reset low for 3 cycles -> all outputs at reset values, ch_sigma=180.
- Basic frame, LAT=2, SEED_CYC=2: start with len=4, snr=8 at T, s_valid always high -> ch_seed high for 2 cycles, 4 consecutive ch_read pulses, ch_sigma=72, 4 m_valid pulses, done one cycle at T+9, sym_count=4.
- Gapped source: len=3 with s_valid low every other cycle -> exactly 3 ch_read, ch_x_* equal to the inputs in order, done 3 cycles after the last handshake.
- Edge commands:
  - len=0 -> done the cycle after start, no ch_seed, no ch_read.
  - snr=12 -> ch_sigma=64 and err_snr=1; next start with snr=3 -> err_snr=0, ch_sigma=128.
- Start while busy: a second start during RUN -> ignored; sym_count reaches the first len only.
- Mid-frame reset: reset low after 2 of 5 symbols -> outputs at reset values next cycle, no m_valid or done afterwards; a new start then runs a clean frame.
